muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; the multi-cycle counterpart of the single-cycle ALU.

---
 rtl/rv_muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter_core.sv | 36 +++
 rtl/muldiv_unit.sv | 135 +++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_e;

    // Most negative two's-complement value of the given width, zero-extended to 64 bits.
    function automatic logic [63:0] min_int(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the datapath: right-shifting shift-add multiply or restoring divide step.
module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic             i_is_div,
    input  logic [2*W-1:0]   i_acc,
    input  logic [W:0]       i_a,
    input  logic [W:0]       i_b,
    output logic [2*W-1:0]   o_acc,
    output logic [W:0]       o_b
);

    logic [W:0] w_add_sum;
    logic [W:0] w_trial;
    logic [W:0] w_diff;

    always_comb begin
        w_add_sum = {1'b0, i_acc[2*W-1:W]} + (i_b[0] ? i_a : '0);
        w_trial   = i_acc[2*W-1:W-1];
        // Remainder stays below the divisor, so the difference fits W+1 bits with bit W as sign.
        w_diff    = w_trial - i_b;
        o_acc     = '0;
        o_b       = i_b;
        if (i_is_div) begin
            if (!w_diff[W]) begin
                o_acc = {w_diff[W-1:0], i_acc[W-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[W-1:0], i_acc[W-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_add_sum, i_acc[W-1:1]};
            o_b   = i_b >> 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with Start/Busy/Done handshake.
//   state | meaning
//   IDLE  | waiting for Start
//   CALC  | one multiply/divide iteration per cycle
//   FIX   | sign correction and result selection
//   DONE  | Result valid, Done pulses
module muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [2:0]            MulDivOp,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [63:0]  MIN_INT_WIDE = min_int(DATA_WIDTH);
    localparam logic [W-1:0] MIN_INT      = MIN_INT_WIDE[W-1:0];

    muldiv_state_e    r_state, w_state_next;
    muldiv_op_e       r_op;
    logic             r_sign_a, r_sign_b;
    logic [W:0]       r_a, r_b;
    logic [2*W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_result;

    muldiv_op_e       w_op;
    logic             w_accept, w_sign_a, w_sign_b, w_div_zero, w_ovf, w_special;
    logic [W:0]       w_ext_a, w_ext_b, w_mag_a, w_mag_b;
    logic [W-1:0]     w_special_result, w_fix_result;
    logic [2*W-1:0]   w_core_acc, w_prod;
    logic [W:0]       w_core_b;

    muldiv_iter_core #(.W(W)) u_core (
        .i_is_div (r_op[2]),
        .i_acc    (r_acc),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_acc    (w_core_acc),
        .o_b      (w_core_b)
    );

    always_comb begin
        w_op       = muldiv_op_e'(MulDivOp);
        w_accept   = Start && (r_state == IDLE);
        w_sign_a   = SrcA[W-1] && (w_op == OP_MUL || w_op == OP_MULH || w_op == OP_MULHSU ||
                                   w_op == OP_DIV || w_op == OP_REM);
        w_sign_b   = SrcB[W-1] && (w_op == OP_MUL || w_op == OP_MULH ||
                                   w_op == OP_DIV || w_op == OP_REM);
        // One extra bit keeps |MIN_INT| representable.
        w_ext_a    = {w_sign_a, SrcA};
        w_ext_b    = {w_sign_b, SrcB};
        w_mag_a    = w_sign_a ? -w_ext_a : w_ext_a;
        w_mag_b    = w_sign_b ? -w_ext_b : w_ext_b;
        w_div_zero = MulDivOp[2] && (SrcB == '0);
        w_ovf      = (w_op == OP_DIV || w_op == OP_REM) && (SrcA == MIN_INT) && (SrcB == '1);
        w_special  = w_div_zero || w_ovf;
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = MulDivOp[1] ? SrcA : '1;
        end else if (w_ovf) begin
            w_special_result = MulDivOp[1] ? '0 : MIN_INT;
        end
    end

    always_comb begin
        w_prod       = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*W-1:W];
            OP_DIV, OP_DIVU:              w_fix_result = (r_sign_a ^ r_sign_b) ? -r_acc[W-1:0]
                                                                               : r_acc[W-1:0];
            default:                      w_fix_result = r_sign_a ? -r_acc[2*W-1:W]
                                                                  : r_acc[2*W-1:W];
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (Start) w_state_next = w_special ? DONE : CALC;
            CALC: if (r_cnt == CNT_W'(W - 1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op     <= w_op;
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_a      <= w_mag_a;
                r_b      <= w_mag_b;
                r_cnt    <= '0;
                r_acc    <= MulDivOp[2] ? {{W{1'b0}}, w_mag_a[W-1:0]} : '0;
                if (w_special) r_result <= w_special_result;
            end else if (r_state == CALC) begin
                r_acc <= w_core_acc;
                r_b   <= w_core_b;
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == FIX) begin
                r_result <= w_fix_result;
            end
        end
    end

    assign Busy   = (r_state != IDLE);
    assign Done   = (r_state == DONE);
    assign Result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, special cases, Start masking, abort.
module tb_muldiv_unit;
    import rv_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, Start;
    logic [2:0]  MulDivOp;
    logic [31:0] SrcA, SrcB, Result;
    logic        Busy, Done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc, pulses;
    logic [31:0] res;
    logic        busy_ok;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .MulDivOp (MulDivOp),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op for a single cycle; report the cycle Done is seen (0 on timeout).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int c, output logic [31:0] r, output logic bz);
        @(negedge clk);
        MulDivOp = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        c = 0; r = 'x; bz = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            if (Done) begin
                c = n; r = Result;
                break;
            end
            if (!Busy) bz = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; MulDivOp = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_result", Result, 32'd0);
        rst = 1'b0;

        do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, cyc, res, busy_ok);
        check("mul_latency", cyc, 32'd34);
        check("mul_busy", {31'd0, busy_ok}, 32'd1);
        check("mul_result", res, 32'hFFFF_FFEB);
        @(negedge clk);
        check("mul_done_pulse", {31'd0, Done}, 32'd0);
        check("mul_idle_busy", {31'd0, Busy}, 32'd0);
        check("mul_result_hold", Result, 32'hFFFF_FFEB);

        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, res, busy_ok);
        check("mulhu", res, 32'hFFFF_FFFE);
        do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, res, busy_ok);
        check("mulh", res, 32'h0000_0000);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, res, busy_ok);
        check("mulhsu", res, 32'hFFFF_FFFF);
        do_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, cyc, res, busy_ok);
        check("mulh_minint", res, 32'h4000_0000);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc, res, busy_ok);
        check("div_latency", cyc, 32'd34);
        check("div", res, 32'hFFFF_FFFD);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, cyc, res, busy_ok);
        check("rem", res, 32'hFFFF_FFFF);
        do_op(OP_DIVU, 32'd100, 32'd7, cyc, res, busy_ok);
        check("divu", res, 32'd14);
        do_op(OP_REMU, 32'd100, 32'd7, cyc, res, busy_ok);
        check("remu", res, 32'd2);

        do_op(OP_DIVU, 32'h1234, 32'd0, cyc, res, busy_ok);
        check("divu0_latency", cyc, 32'd1);
        check("divu0", res, 32'hFFFF_FFFF);
        do_op(OP_REM, 32'h1234, 32'd0, cyc, res, busy_ok);
        check("rem0_latency", cyc, 32'd1);
        check("rem0", res, 32'h0000_1234);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, res, busy_ok);
        check("divovf_latency", cyc, 32'd1);
        check("divovf", res, 32'h8000_0000);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, cyc, res, busy_ok);
        check("removf_latency", cyc, 32'd1);
        check("removf", res, 32'h0000_0000);

        // Start held high with operands changed mid-CALC.
        @(negedge clk);
        MulDivOp = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        MulDivOp = OP_MUL; SrcA = 32'd6; SrcB = 32'd7;
        cyc = 0;
        for (int n = 4; n <= 100; n++) begin
            if (Done) begin
                cyc = n; res = Result;
                break;
            end
            @(negedge clk);
        end
        check("held_latency", cyc, 32'd34);
        check("held_result", res, 32'd14);
        @(negedge clk);
        check("held_idle", {31'd0, Busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        check("reaccept_busy", {31'd0, Busy}, 32'd1);
        cyc = 0;
        for (int n = 1; n <= 100; n++) begin
            if (Done) begin
                cyc = n; res = Result;
                break;
            end
            @(negedge clk);
        end
        check("reaccept_latency", cyc, 32'd34);
        check("reaccept_result", res, 32'd42);

        // Reset at iteration 10 of a multiply.
        @(negedge clk);
        MulDivOp = OP_MUL; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_result", Result, 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);
        check("abort_stays_idle", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
